// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: resets to RESET_PC, steps by one instruction, loads redirect targets word-aligned.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_inc,
    input  logic                     i_load,
    input  logic [ADDRESS_WIDTH-1:0] i_load_pc,
    output logic [ADDRESS_WIDTH-1:0] o_pc
);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] w_target;

    assign w_target = i_load_pc & ~ADDRESS_WIDTH'(3);

    // Load wins over increment so a redirect overrides a completing fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_target;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDRESS_WIDTH'(INSTR_BYTES);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding imem read, output buffer to decode, redirect with squash.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    output logic                     o_imem_req,
    output logic [ADDRESS_WIDTH-1:0] o_imem_addr,
    input  logic                     i_imem_gnt,
    input  logic                     i_imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    i_imem_rdata,
    output logic                     o_instr_valid,
    output logic [DATA_WIDTH-1:0]    o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_instr_pc,
    input  logic                     i_instr_ready,
    input  logic                     i_redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc
);

    fetch_state_t             r_state;
    logic                     r_drop;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [ADDRESS_WIDTH-1:0] r_instr_pc;
    logic [ADDRESS_WIDTH-1:0] w_pc;
    logic                     w_accept;

    assign w_accept = (r_state == S_WAIT) && i_imem_rvalid && !r_drop && !i_redirect;

    fetch_pc #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .RESET_PC     (RESET_PC)
    ) u_pc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_inc    (w_accept),
        .i_load   (i_redirect),
        .i_load_pc(i_redirect_pc),
        .o_pc     (w_pc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_drop     <= 1'b0;
            r_instr    <= DATA_WIDTH'(NOP_INSTR);
            r_instr_pc <= RESET_PC;
        end else if (i_redirect) begin
            // Squash: anything granted but not yet returned must be discarded.
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (i_imem_gnt) begin
                        r_state <= S_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        r_state <= S_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                S_HOLD: r_state <= S_REQ;
                default: r_state <= S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (i_imem_gnt) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_instr    <= i_imem_rdata;
                            r_instr_pc <= w_pc;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_instr_ready) r_state <= S_REQ;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_imem_req    = (r_state == S_REQ);
    assign o_imem_addr   = w_pc;
    assign o_instr_valid = (r_state == S_HOLD);
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the reduced RISC-V CPU: owns the program counter, issues word reads to instruction memory over a req/gnt/rvalid interface, and presents each fetched instruction with its PC to the control/decode stage over a valid/ready handshake. Taken-branch redirects from the control path reload the PC and squash any in-flight or buffered fetch. One request outstanding at a time.

## Interface
- ADDRESS_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request, address valid
- imem_addr  out  ADDRESS_WIDTH  word-aligned read address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (≥1 cycle after gnt)
- imem_rdata  in  DATA_WIDTH  instruction word
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  DATA_WIDTH  fetched instruction
- instr_pc  out  ADDRESS_WIDTH  address of instr
- instr_ready  in  1  decode accepts instruction
- redirect  in  1  taken branch / PC override, single-cycle pulse
- redirect_pc  in  ADDRESS_WIDTH  new PC; bits [1:0] ignored (forced 0)

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD. Plus drop flag (discard next response) and pc register.
- S_IDLE: entered on reset only; next cycle -> S_REQ.
- S_REQ: imem_req=1, imem_addr=pc. gnt -> S_WAIT. Address may change while req high and ungranted (redirect).
- S_WAIT: await imem_rvalid. On rvalid with drop=0: capture rdata into instr, pc into instr_pc, pc<=pc+4, -> S_HOLD. On rvalid with drop=1: discard, clear drop, -> S_REQ.
- S_HOLD: instr_valid=1; instr, instr_pc stable until instr_valid&&instr_ready; then -> S_REQ.
- PC arithmetic: modulo 2^ADDRESS_WIDTH; pc+4 from 32'hFFFF_FFFC wraps to 0.
- Redirect (any state, highest priority): pc<=redirect_pc&~3; instr_valid cleared next cycle.
  - S_IDLE: pc loaded, -> S_REQ as normal.
  - S_REQ, no gnt: stay S_REQ; imem_addr = new pc next cycle.
  - S_REQ with gnt same cycle: -> S_WAIT, drop<=1.
  - S_WAIT, no rvalid: stay, drop<=1. S_WAIT with rvalid: data discarded, -> S_REQ.
  - S_HOLD: buffer discarded (handshake completing that cycle still counts as accepted), -> S_REQ.
- rvalid while not in S_WAIT: ignored (protocol violation, assertion in bench).

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, pc=RESET_PC, drop=0, state=S_IDLE.
- imem_req, imem_addr, instr_valid decoded from registered state/pc only; no combinational path from any input to any output.
- Best case after rst release: cycle 1 imem_req; gnt in cycle 1, rvalid cycle 2 -> instr_valid cycle 3.
- Steady state with zero-wait memory and ready=1: one instruction per 3 cycles.
- Redirect in cycle n: imem_req for redirect_pc earliest in cycle n+1 (unless a dropped response is still owed).
- rst mid-operation: all state to reset values next edge; an outstanding response arriving after reset is ignored (state S_IDLE/S_REQ).

## Structure
- Package fetch_pkg: state enum fetch_state_t, INSTR_BYTES=4, NOP_INSTR=32'h0000_0013.
- Sub-module fetch_pc: PC register with reset-to-RESET_PC, increment-by-4, and redirect load (alignment masking inside); fetch_unit holds FSM, drop flag, output buffer.

## Test plan
- Reset then memory gnt same cycle, rvalid +1, ready=1: addresses 0x0,0x4,0x8 requested; instr_pc 0x0,0x4,0x8 with matching rdata; outputs at reset values during rst.
- Backpressure: ready=0 for 5 cycles in S_HOLD: instr/instr_pc stable, imem_req=0; ready=1 -> next req at pc+4.
- Redirect to 0x103 while S_WAIT, rvalid 2 cycles later with 0xDEADBEEF: data dropped, instr_valid never shows it, next req addr 0x100, instr_pc 0x100.
- Redirect in same cycle as gnt for 0x8 (target 0x40): response for 0x8 dropped, next req 0x40.
- Redirect during ungranted req (gnt held 0): imem_addr switches to redirect target next cycle, req stays 1.
- Wrap: redirect to 0xFFFF_FFFC, fetch completes -> next imem_addr 0x0000_0000; rst asserted during S_WAIT -> state S_IDLE, late rvalid ignored, next req RESET_PC.
